// File: rtl/shift_sequencer_if.sv
// Request, result and shifter-side signals of the shift sequencer.
// slave is the sequencer's view; master is the surrounding system's view.
interface shift_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic [31:0] sh_a;
  logic [4:0]  sh_s;
  logic [31:0] sh_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport slave (
    input  in_valid, in_op, in_data, in_amt, sh_out, out_ready,
    output in_ready, sh_a, sh_s, out_valid, out_data
  );

  modport master (
    output in_valid, in_op, in_data, in_amt, sh_out, out_ready,
    input  in_ready, sh_a, sh_s, out_valid, out_data
  );
endinterface

// File: rtl/shift_sequencer.sv
// Drives an external 32-bit logical-right barrel shifter to produce SRL, SLL,
// SRA and ROR, using bit reversal and a second pass where needed.
module shift_sequencer (
  input  logic             clk,
  input  logic             rst,
  shift_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PASS1 = 2'd1;
  localparam logic [1:0] PASS2 = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] OP_SRL = 2'd0;
  localparam logic [1:0] OP_SLL = 2'd1;
  localparam logic [1:0] OP_SRA = 2'd2;
  localparam logic [1:0] OP_ROR = 2'd3;

  logic [1:0]  state;
  logic [1:0]  op_r;
  logic [31:0] data_r;
  logic [4:0]  amt_r;
  logic [31:0] acc;
  logic [31:0] term2;

  function automatic logic [31:0] rev(input logic [31:0] x);
    logic [31:0] r;
    for (int unsigned i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  always_comb begin
    bus.sh_a = '0;
    bus.sh_s = '0;
    case (state)
      PASS1: begin
        bus.sh_s = amt_r;
        bus.sh_a = (op_r == OP_SLL) ? rev(data_r) : data_r;
      end
      PASS2: begin
        // ROR: rev(rev(x) >> (32-n)) supplies the bits wrapped in from the left.
        if (op_r == OP_ROR) begin
          bus.sh_a = rev(data_r);
          bus.sh_s = 5'd0 - amt_r;
        end else begin
          bus.sh_a = '1;
          bus.sh_s = amt_r;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    term2 = '0;
    if (op_r == OP_ROR) begin
      if (amt_r != 5'd0) term2 = rev(bus.sh_out);
    end else if (data_r[31]) begin
      term2 = ~bus.sh_out;
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_r   <= '0;
      data_r <= '0;
      amt_r  <= '0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_r   <= bus.in_op;
            data_r <= bus.in_data;
            amt_r  <= bus.in_amt;
            state  <= PASS1;
          end
        end
        PASS1: begin
          acc   <= (op_r == OP_SLL) ? rev(bus.sh_out) : bus.sh_out;
          state <= (op_r == OP_SRA || op_r == OP_ROR) ? PASS2 : DONE;
        end
        PASS2: begin
          acc   <= acc | term2;
          state <= DONE;
        end
        default: begin
          if (bus.out_ready) state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural right shifter on sh_*.
module tb_shift_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  shift_sequencer_if bus ();
  assign bus.sh_out = bus.sh_a >> bus.sh_s;

  shift_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one request while idle, checks latency (edges from accept to the
  // first edge sampling out_valid=1) and the result, then consumes it.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] n, input logic [31:0] exp, input int lat);
    int k;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = d;
    bus.in_amt   = n;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_latency"}, 32'(k + 1), 32'(lat));
    check({tag, "_data"}, bus.out_data, exp);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_handoff"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int k;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'd0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_sh_a", bus.sh_a, 32'd0);
    check("rst_sh_s", 32'(bus.sh_s), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    run_op("srl_n4",  2'd0, 32'h8000_0000, 5'd4,  32'h0800_0000, 2);
    run_op("srl_n0",  2'd0, 32'h8000_0000, 5'd0,  32'h8000_0000, 2);
    run_op("sll_n31", 2'd1, 32'h0000_0001, 5'd31, 32'h8000_0000, 2);
    run_op("sll_n8",  2'd1, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FF00, 2);
    run_op("sra_neg", 2'd2, 32'h8000_0000, 5'd4,  32'hF800_0000, 3);
    run_op("sra_pos", 2'd2, 32'h4000_0000, 5'd4,  32'h0400_0000, 3);
    run_op("sra_n0",  2'd2, 32'hF000_0000, 5'd0,  32'hF000_0000, 3);
    run_op("ror_n1",  2'd3, 32'h0000_0001, 5'd1,  32'h8000_0000, 3);
    run_op("ror_n0",  2'd3, 32'h1234_5678, 5'd0,  32'h1234_5678, 3);
    run_op("ror_n8",  2'd3, 32'h1234_5678, 5'd8,  32'h7812_3456, 3);

    // Backpressure: result held 5 cycles while a second request waits.
    bus.in_valid = 1'b1; bus.in_op = 2'd0; bus.in_data = 32'hA5A5_A5A5; bus.in_amt = 5'd4;
    @(posedge clk); #1;
    bus.in_op = 2'd3; bus.in_data = 32'h0000_00F0; bus.in_amt = 5'd4;
    k = 0;
    while (!bus.out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    held = 32'h0A5A_5A5A;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_data_stable", bus.out_data, held);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_handoff_idle", 32'(bus.in_ready), 32'd1);
    check("bp_handoff_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("b2b_accepted", 32'(bus.in_ready), 32'd0);
    k = 0;
    while (!bus.out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("b2b_latency", 32'(k + 1), 32'd3);
    check("b2b_data", bus.out_data, 32'h0000_000F);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Reset asserted during PASS2 of an SRA.
    bus.in_valid = 1'b1; bus.in_op = 2'd2; bus.in_data = 32'h8000_0000; bus.in_amt = 5'd4;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_pass2_sh_a", bus.sh_a, 32'hFFFF_FFFF);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_out_data", bus.out_data, 32'd0);
    check("abort_sh_a", bus.sh_a, 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("after_rst_sra", 2'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
